// File: rtl/bidir_port_ctrl.sv
// bidir_port_ctrl: Avalon-MM controlled bidirectional pad channels with synchronized
// inputs, per-bit direction, edge capture (write-1-to-clear) and a level interrupt.
module bidir_port_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  localparam int unsigned AW = $clog2(NUM_CH) + 2,
  localparam int unsigned PW = NUM_CH * DATA_W
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic          avs_readdatavalid,
  input  logic [PW-1:0] port_in,
  output logic [PW-1:0] port_out,
  output logic [PW-1:0] port_oe,
  output logic          irq
);

  localparam int unsigned ARM_N = SYNC_STAGES + 1;
  localparam int unsigned ARM_W = $clog2(ARM_N + 1);
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_DIR  = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_CAP  = 2'd3;

  logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
  logic [PW-1:0]                  r_prev;
  logic [ARM_W-1:0]               r_arm;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_out;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_dir;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_mask;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_cap;
  logic [31:0]                    r_rdata;
  logic                           r_rvalid;
  logic                           r_irq;

  logic [PW-1:0]                  w_sync;
  logic [PW-1:0]                  w_edge;
  logic [31:0]                    w_ch;
  logic [1:0]                     w_reg;
  logic [DATA_W-1:0]              w_wdata;
  logic [DATA_W-1:0]              w_rsel;
  logic [NUM_CH-1:0][DATA_W-1:0]  w_cap_nxt;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_reg   = avs_address[1:0];
  assign w_ch    = 32'(avs_address >> 2);
  assign w_wdata = avs_writedata[DATA_W-1:0];

  // Pad synchronizer, delayed copy for edge detection, and post-reset arming counter
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_arm  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], port_in};
      r_prev <= w_sync;
      if (r_arm != ARM_W'(ARM_N)) r_arm <= r_arm + ARM_W'(1);
    end
  end

  always_comb begin
    w_edge = '0;
    if (r_arm == ARM_W'(ARM_N)) begin
      case (EDGE_TYPE)
        0:       w_edge = w_sync & ~r_prev;
        1:       w_edge = ~w_sync & r_prev;
        default: w_edge = w_sync ^ r_prev;
      endcase
    end
  end

  // A new edge overrides a simultaneous write-1-to-clear
  always_comb begin
    w_cap_nxt = r_cap;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (avs_write && (w_ch == c) && (w_reg == REG_CAP))
        w_cap_nxt[c] = r_cap[c] & ~w_wdata;
      w_cap_nxt[c] = w_cap_nxt[c] | w_edge[c*DATA_W +: DATA_W];
    end
  end

  // Out-of-range channels never match, so they read as zero
  always_comb begin
    w_rsel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_ch == c) begin
        case (w_reg)
          REG_DATA: w_rsel = w_sync[c*DATA_W +: DATA_W];
          REG_DIR:  w_rsel = r_dir[c];
          REG_MASK: w_rsel = r_mask[c];
          default:  w_rsel = r_cap[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (avs_write && (w_ch == c)) begin
          case (w_reg)
            REG_DATA: r_out[c]  <= w_wdata;
            REG_DIR:  r_dir[c]  <= w_wdata;
            REG_MASK: r_mask[c] <= w_wdata;
            default:  ;
          endcase
        end
      end
      r_cap <= w_cap_nxt;
    end
  end

  // Read response and interrupt, both one cycle behind their sources
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_rvalid <= avs_read;
      if (avs_read) r_rdata <= 32'(w_rsel);
      r_irq <= |(r_cap & r_mask);
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign port_out          = r_out;
  assign port_oe           = r_dir;
  assign irq               = r_irq;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Self-checking bench for bidir_port_ctrl: directed scenarios plus randomized traffic
// compared against a history-queue reference model.
module tb_bidir_port_ctrl;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned SS  = 2;
  localparam int unsigned AW  = $clog2(NCH) + 2;
  localparam int unsigned PW  = NCH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic [PW-1:0] port_in;
  logic [PW-1:0] port_out;
  logic [PW-1:0] port_oe;
  logic          irq;
  logic [PW-1:0] pin_drv = '1;
  logic          loop_en = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  // Pads: driven bits show the output latch, undriven bits show the external source
  assign port_in = loop_en ? ((port_out & port_oe) | (pin_drv & ~port_oe)) : pin_drv;

  bidir_port_ctrl #(.DATA_W(DW), .NUM_CH(NCH), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .port_in(port_in), .port_out(port_out), .port_oe(port_oe), .irq(irq)
  );

  // Reference model: pad history queue gives the synchronized and delayed views
  logic [31:0]   m_out [NCH];
  logic [31:0]   m_dir [NCH];
  logic [31:0]   m_mask[NCH];
  logic [31:0]   m_cap [NCH];
  logic [31:0]   m_rdata;
  logic          m_rvalid;
  logic          m_irq;
  logic [PW-1:0] hist[$];
  logic [PW-1:0] m_cur, m_prv, m_edges;
  int unsigned   m_cyc, m_ch, m_rg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_out[i] = '0; m_dir[i] = '0; m_mask[i] = '0; m_cap[i] = '0;
      end
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0; m_cyc = 0;
      hist.delete();
      for (int i = 0; i < SS + 2; i++) hist.push_front('0);
    end else begin
      m_cyc++;
      hist.push_front(port_in);
      m_cur = hist[SS];
      m_prv = hist[SS+1];
      hist = hist[0:SS+1];
      m_edges = (m_cyc >= SS + 2) ? (m_cur & ~m_prv) : '0;
      m_irq = 1'b0;
      for (int c = 0; c < NCH; c++) m_irq = m_irq | (|(m_cap[c] & m_mask[c]));
      m_ch = int'(avs_address) / 4;
      m_rg = int'(avs_address) % 4;
      m_rvalid = avs_read;
      if (avs_read) begin
        if (m_ch >= NCH) m_rdata = '0;
        else case (m_rg)
          0: m_rdata = m_cur[m_ch*DW +: DW];
          1: m_rdata = m_dir[m_ch];
          2: m_rdata = m_mask[m_ch];
          default: m_rdata = m_cap[m_ch];
        endcase
      end
      if (avs_write && m_ch < NCH) begin
        case (m_rg)
          0: m_out[m_ch] = avs_writedata;
          1: m_dir[m_ch] = avs_writedata;
          2: m_mask[m_ch] = avs_writedata;
          default: m_cap[m_ch] = m_cap[m_ch] & ~avs_writedata;
        endcase
      end
      for (int c = 0; c < NCH; c++) m_cap[c] = m_cap[c] | m_edges[c*DW +: DW];
    end
  end

  function automatic logic [AW-1:0] addr(input int unsigned ch, input int unsigned rg);
    return AW'(ch * 4 + rg);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d, output logic v);
    avs_address = a; avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    d = avs_readdata; v = avs_readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst_n = 1'b0; pin_drv = '1; loop_en = 1'b0;
    repeat (3) step();
    n_checks++;
    if (port_out !== '0 || port_oe !== '0 || irq !== 1'b0 || avs_readdatavalid !== 1'b0
        || avs_readdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%h oe=%h irq=%b rv=%b rd=%h required all 0",
               port_out, port_oe, irq, avs_readdatavalid, avs_readdata);
    end
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      bus_write(addr(c, 2), '1);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL arm_irq: got %b required 0", irq); end
    end
    for (int i = 0; i < 17; i++) begin
      step();
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL arm_irq: got %b required 0", irq); end
    end
    for (int c = 0; c < NCH; c++) begin
      bus_read(addr(c, 3), d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        n_fail++; $display("FAIL arm_edgecap ch%0d: got %h/%b required 0/1", c, d, v);
      end
    end
  endtask

  task automatic test_dir_data();
    logic [31:0] d; logic v;
    pin_drv = '0; pin_drv[31:0] = 32'h1234_0000; loop_en = 1'b1;
    bus_write(addr(0, 1), 32'h0000_FFFF);
    n_checks++;
    if (port_oe[31:0] !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL dir_oe: got %h required 0000ffff", port_oe[31:0]);
    end
    bus_write(addr(0, 0), 32'h1234_ABCD);
    n_checks++;
    if (port_out[31:0] !== 32'h1234_ABCD) begin
      n_fail++; $display("FAIL data_out: got %h required 1234abcd", port_out[31:0]);
    end
    step(); step();
    bus_read(addr(0, 0), d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h1234_ABCD) begin
      n_fail++; $display("FAIL loopback_read: got %h/%b required 1234abcd/1", d, v);
    end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d; logic v; int unsigned lat; logic found;
    loop_en = 1'b0; pin_drv[32] = 1'b0;
    bus_write(addr(0, 2), 32'h0);
    bus_write(addr(1, 2), 32'h1);
    bus_write(addr(2, 2), 32'h0);
    repeat (4) step();
    for (int c = 0; c < NCH; c++) bus_write(addr(c, 3), '1);
    step();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b required 0", irq); end
    pin_drv[32] = 1'b1;
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      step();
      if (irq === 1'b1) begin found = 1'b1; lat = i; end
    end
    n_checks++;
    if (!found || lat > SS + 2) begin
      n_fail++; $display("FAIL irq_rise: seen=%b latency=%0d required within %0d", found, lat, SS + 2);
    end
    bus_read(addr(1, 3), d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h1) begin
      n_fail++; $display("FAIL edgecap_ch1: got %h/%b required 00000001/1", d, v);
    end
    bus_write(addr(1, 3), 32'h1);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b required 1", irq); end
    step();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b required 0", irq); end
  endtask

  task automatic test_edge_clear_collision();
    logic [31:0] d; logic v;
    pin_drv[0] = 1'b0;
    repeat (5) step();
    bus_write(addr(0, 3), '1);
    pin_drv[0] = 1'b1;
    step(); step();
    bus_write(addr(0, 3), 32'h1);
    bus_read(addr(0, 3), d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h1) begin
      n_fail++; $display("FAIL edge_beats_clear: got %h/%b required 00000001/1", d, v);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic v;
    logic [31:0] exp_mask [NCH];
    exp_mask[0] = 32'h0; exp_mask[1] = 32'h1; exp_mask[2] = 32'h0;
    avs_writedata = '1;
    bus_read(addr(3, 0), d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL oor_read: got %h/%b required 00000000/1", d, v);
    end
    step();
    n_checks++;
    if (avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL oor_valid_pulse: got %b required 0", avs_readdatavalid);
    end
    for (int rg = 0; rg < 4; rg++) bus_write(addr(3, rg), '1);
    step();
    n_checks++;
    if (port_out !== {64'h0, 32'h1234_ABCD} || port_oe !== {64'h0, 32'h0000_FFFF}) begin
      n_fail++; $display("FAIL oor_write_pads: out=%h oe=%h required unchanged", port_out, port_oe);
    end
    for (int c = 0; c < NCH; c++) begin
      bus_read(addr(c, 2), d, v);
      n_checks++;
      if (d !== exp_mask[c]) begin
        n_fail++; $display("FAIL oor_mask ch%0d: got %h required %h", c, d, exp_mask[c]);
      end
    end
    bus_read(addr(0, 3), d, v);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL oor_edgecap: got %h required 00000001", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = pin_drv[31:0]; exp[1] = 32'h0000_FFFF; exp[2] = 32'h0; exp[3] = 32'h1;
    for (int rg = 0; rg < 4; rg++) begin
      avs_address = addr(0, rg); avs_read = 1'b1;
      step();
      n_checks++;
      if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp[rg]) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got %h/%b required %h/1", rg, avs_readdata, avs_readdatavalid, exp[rg]);
      end
    end
    avs_read = 1'b0;
    step();
    n_checks++;
    if (avs_readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got %b required 0", avs_readdatavalid);
    end
    for (int rg = 0; rg < 2; rg++) begin
      avs_address = addr(0, rg); avs_read = 1'b1;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (avs_readdatavalid !== 1'b0 || avs_readdata !== '0 || irq !== 1'b0 || port_oe !== '0
        || port_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rv=%b rd=%h irq=%b oe=%h out=%h required all 0",
               avs_readdatavalid, avs_readdata, irq, port_oe, port_out);
    end
    avs_read = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (avs_readdatavalid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_valid: got %b required 0", avs_readdatavalid);
      end
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] exp_out, exp_oe;
    loop_en = 1'b1;
    for (int c = 0; c < NCH; c++) bus_write(addr(c, 2), $urandom);
    for (int n = 0; n < 2000; n++) begin
      avs_read      = 1'($urandom_range(0, 1));
      avs_write     = ($urandom_range(0, 2) == 0);
      avs_address   = AW'($urandom_range(0, 15));
      avs_writedata = $urandom;
      if ($urandom_range(0, 3) == 0) pin_drv[$urandom_range(0, PW - 1)] ^= 1'b1;
      if (n == 1000) loop_en = 1'b0;
      step();
      for (int c = 0; c < NCH; c++) begin
        exp_out[c*DW +: DW] = m_out[c];
        exp_oe[c*DW +: DW]  = m_dir[c];
      end
      n_checks++;
      if (port_out !== exp_out || port_oe !== exp_oe || irq !== m_irq
          || avs_readdatavalid !== m_rvalid || (m_rvalid && avs_readdata !== m_rdata)) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: out=%h oe=%h irq=%b rv=%b rd=%h required out=%h oe=%h irq=%b rv=%b rd=%h",
                 n, port_out, port_oe, irq, avs_readdatavalid, avs_readdata,
                 exp_out, exp_oe, m_irq, m_rvalid, m_rdata);
      end
    end
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_dir_data();
    test_edge_irq();
    test_edge_clear_collision();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
